// File: rtl/fp_add_pipe.sv
// Three-stage pipelined floating-point adder/subtractor with valid/ready back-pressure.
// Define FP_ADD_PIPE_ROUND_RNE_EN for round-to-nearest-even; otherwise results truncate.
module fp_add_pipe #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23,
  parameter int unsigned TAG_W = 4
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iValid,
  output logic                   oReady,
  input  logic [EXP_W+MAN_W:0]   iA,
  input  logic [EXP_W+MAN_W:0]   iB,
  input  logic                   iSub,
  input  logic [TAG_W-1:0]       iTag,
  output logic                   oValid,
  input  logic                   iReady,
  output logic [EXP_W+MAN_W:0]   oSum,
  output logic [TAG_W-1:0]       oTag
);

  localparam int unsigned W = EXP_W + MAN_W + 1;
  localparam int unsigned N = MAN_W + 4;
  localparam int EXP_MAX = (1 << EXP_W) - 1;

  logic en;

  logic             s1_valid_q, s1_sign_q, s1_sub_q, s1_spec_q;
  logic [EXP_W-1:0] s1_exp_q;
  logic [N-1:0]     s1_big_q, s1_small_q;
  logic [W-1:0]     s1_spec_val_q;
  logic [TAG_W-1:0] s1_tag_q;

  logic             s2_valid_q, s2_sign_q, s2_spec_q;
  logic [EXP_W-1:0] s2_exp_q;
  logic [N:0]       s2_sum_q;
  logic [W-1:0]     s2_spec_val_q;
  logic [TAG_W-1:0] s2_tag_q;

  logic             s3_valid_q;
  logic [W-1:0]     s3_sum_q;
  logic [TAG_W-1:0] s3_tag_q;

  assign en     = ~s3_valid_q | iReady;
  assign oReady = en;
  assign oValid = s3_valid_q;
  assign oSum   = s3_sum_q;
  assign oTag   = s3_tag_q;

  // Stage 1: sign adjust, operand ordering, alignment and special-case detection
  logic [EXP_W-1:0] a_exp, b_exp, big_exp, small_exp;
  logic [MAN_W-1:0] big_frac, small_frac;
  logic             b_sign, a_big, big_sign, small_sign, spec;
  logic [W-1:0]     b_adj, spec_val;
  logic [N-1:0]     big_sig, small_sig, aligned;
  logic [2*N-1:0]   ext;
  int               diff;

  always_comb begin
    a_exp      = iA[W-2:MAN_W];
    b_exp      = iB[W-2:MAN_W];
    b_sign     = iB[W-1] ^ iSub;
    b_adj      = {b_sign, iB[W-2:0]};
    a_big      = iA[W-2:0] >= iB[W-2:0];
    big_sign   = a_big ? iA[W-1] : b_sign;
    small_sign = a_big ? b_sign : iA[W-1];
    big_exp    = a_big ? a_exp : b_exp;
    small_exp  = a_big ? b_exp : a_exp;
    big_frac   = a_big ? iA[MAN_W-1:0] : iB[MAN_W-1:0];
    small_frac = a_big ? iB[MAN_W-1:0] : iA[MAN_W-1:0];
    big_sig    = {1'b1, big_frac, 3'b000};
    small_sig  = {1'b1, small_frac, 3'b000};
    diff       = int'(big_exp) - int'(small_exp);
    ext        = {small_sig, {N{1'b0}}} >> diff;
    // Zero-exponent operands are caught as specials, so a far-shifted operand is never zero.
    if (diff > int'(N) - 1) aligned = {{(N-1){1'b0}}, 1'b1};
    else                    aligned = {ext[2*N-1:N+1], ext[N] | (|ext[N-1:0])};

    spec     = 1'b1;
    spec_val = '0;
    if (&a_exp)                       spec_val = iA;
    else if (&b_exp)                  spec_val = b_adj;
    else if (a_exp == '0 && b_exp == '0) spec_val = '0;
    else if (a_exp == '0)             spec_val = b_adj;
    else if (b_exp == '0)             spec_val = iA;
    else                              spec     = 1'b0;
  end

  // Stage 2: magnitude add or subtract (larger minus smaller)
  logic [N:0] sum_d;

  always_comb begin
    if (s1_sub_q) sum_d = {1'b0, s1_big_q} - {1'b0, s1_small_q};
    else          sum_d = {1'b0, s1_big_q} + {1'b0, s1_small_q};
  end

  // Stage 3: normalise, optional rounding, range checks and packing
  logic [W-1:0]     res;
  logic [MAN_W-1:0] frac;
  logic             found;
  int               lz, exp_n;
`ifdef FP_ADD_PIPE_ROUND_RNE_EN
  logic [N-1:0]     norm;
  logic [MAN_W+1:0] mant;
  logic             round_up;
`endif

  always_comb begin
    lz    = 0;
    found = 1'b0;
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (!found && s2_sum_q[i]) begin
        lz    = int'(N) - 1 - i;
        found = 1'b1;
      end
    end
    exp_n = s2_sum_q[N] ? int'(s2_exp_q) + 1 : int'(s2_exp_q) - lz;
`ifdef FP_ADD_PIPE_ROUND_RNE_EN
    if (s2_sum_q[N]) norm = {s2_sum_q[N:2], |s2_sum_q[1:0]};
    else             norm = s2_sum_q[N-1:0] << lz;
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    mant     = {1'b0, norm[N-1:3]} + (MAN_W+2)'(round_up);
    if (mant[MAN_W+1]) exp_n = exp_n + 1;
    frac = mant[MAN_W+1] ? mant[MAN_W:1] : mant[MAN_W-1:0];
`else
    if (s2_sum_q[N]) frac = MAN_W'(s2_sum_q >> 4);
    else             frac = MAN_W'((s2_sum_q[N-1:0] << lz) >> 3);
`endif
    if (s2_spec_q)            res = s2_spec_val_q;
    else if (s2_sum_q == '0)  res = '0;
    else if (exp_n <= 0)      res = '0;
    else if (exp_n >= EXP_MAX) res = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else                      res = {s2_sign_q, exp_n[EXP_W-1:0], frac};
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      s1_valid_q    <= 1'b0;
      s1_sign_q     <= 1'b0;
      s1_sub_q      <= 1'b0;
      s1_spec_q     <= 1'b0;
      s1_exp_q      <= '0;
      s1_big_q      <= '0;
      s1_small_q    <= '0;
      s1_spec_val_q <= '0;
      s1_tag_q      <= '0;
      s2_valid_q    <= 1'b0;
      s2_sign_q     <= 1'b0;
      s2_spec_q     <= 1'b0;
      s2_exp_q      <= '0;
      s2_sum_q      <= '0;
      s2_spec_val_q <= '0;
      s2_tag_q      <= '0;
      s3_valid_q    <= 1'b0;
      s3_sum_q      <= '0;
      s3_tag_q      <= '0;
    end else if (en) begin
      s1_valid_q    <= iValid;
      s1_sign_q     <= big_sign;
      s1_sub_q      <= big_sign ^ small_sign;
      s1_spec_q     <= spec;
      s1_exp_q      <= big_exp;
      s1_big_q      <= big_sig;
      s1_small_q    <= aligned;
      s1_spec_val_q <= spec_val;
      s1_tag_q      <= iTag;
      s2_valid_q    <= s1_valid_q;
      s2_sign_q     <= s1_sign_q;
      s2_spec_q     <= s1_spec_q;
      s2_exp_q      <= s1_exp_q;
      s2_sum_q      <= sum_d;
      s2_spec_val_q <= s1_spec_val_q;
      s2_tag_q      <= s1_tag_q;
      s3_valid_q    <= s2_valid_q;
      s3_sum_q      <= res;
      s3_tag_q      <= s2_tag_q;
    end
  end

endmodule

// File: tb/tb_fp_add_pipe.sv
// Directed bench for fp_add_pipe: fp32 vector table, stall/stream, mid-flight reset, fp16 build.
module tb_fp_add_pipe;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] want;
  } vec_t;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        sub;
    logic [15:0] want;
  } hvec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, o_ready, sub, o_valid, ready;
  logic [31:0] a, b, o_sum;
  logic [3:0]  tag, o_tag;

  logic        h_valid, h_ready, h_sub, h_ovalid;
  logic [15:0] h_a, h_b, h_sum;
  logic [3:0]  h_tag, h_otag;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  fp_add_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
    .iCLK(clk), .iRST(rst), .iValid(in_valid), .oReady(o_ready), .iA(a), .iB(b),
    .iSub(sub), .iTag(tag), .oValid(o_valid), .iReady(ready), .oSum(o_sum), .oTag(o_tag)
  );

  fp_add_pipe #(.EXP_W(5), .MAN_W(10), .TAG_W(4)) dut_h (
    .iCLK(clk), .iRST(rst), .iValid(h_valid), .oReady(h_ready), .iA(h_a), .iB(h_b),
    .iSub(h_sub), .iTag(h_tag), .oValid(h_ovalid), .iReady(1'b1), .oSum(h_sum), .oTag(h_otag)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_tests++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Issue one op into the fp32 instance and wait (bounded) for its result.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                        input logic [3:0] itag, output logic [31:0] res,
                        output logic [3:0] rtag, output int lat);
    @(negedge clk);
    a = ia; b = ib; sub = isub; tag = itag; in_valid = 1'b1;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (!o_valid && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res  = o_sum;
    rtag = o_tag;
  endtask

  function automatic logic [31:0] stream_want(input int i);
    return 32'h3F80_0000 + (32'(i + 1) << 23);
  endfunction

  vec_t        vecs[14];
  hvec_t       hvecs[2];
  logic [31:0] res;
  logic [3:0]  rtag;
  int          lat, sent, recv;

  initial begin
    vecs[0]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000};
    vecs[1]  = '{32'h3FC0_0000, 32'h3E80_0000, 1'b1, 32'h3FA0_0000};
    vecs[2]  = '{32'h3F80_0000, 32'hBF80_0000, 1'b0, 32'h0000_0000};
    vecs[3]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000};
    vecs[4]  = '{32'h0000_0001, 32'h3F80_0000, 1'b0, 32'h3F80_0000};
`ifdef FP_ADD_PIPE_ROUND_RNE_EN
    vecs[5]  = '{32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0001};
`else
    vecs[5]  = '{32'h3F80_0000, 32'h33C0_0000, 1'b0, 32'h3F80_0000};
`endif
    vecs[6]  = '{32'h7F80_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0000};
    vecs[7]  = '{32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000};
    vecs[8]  = '{32'h3F80_0000, 32'h4000_0000, 1'b1, 32'hBF80_0000};
    vecs[9]  = '{32'h0080_0001, 32'h0080_0000, 1'b1, 32'h0000_0000};
    vecs[10] = '{32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000};
    vecs[11] = '{32'hFF80_0000, 32'h3F80_0000, 1'b0, 32'hFF80_0000};
    vecs[12] = '{32'h4000_0000, 32'h3F80_0000, 1'b0, 32'h4040_0000};
    vecs[13] = '{32'h3F80_0000, 32'h0080_0000, 1'b0, 32'h3F80_0000};
    hvecs[0] = '{16'h3C00, 16'h3C00, 1'b0, 16'h4000};
    hvecs[1] = '{16'h3C00, 16'h3800, 1'b1, 16'h3800};

    rst = 1'b1; in_valid = 1'b0; ready = 1'b1; a = '0; b = '0; sub = 1'b0; tag = '0;
    h_valid = 1'b0; h_a = '0; h_b = '0; h_sub = 1'b0; h_tag = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_sum", o_sum, 32'd0);
    check("reset_tag", 32'(o_tag), 32'd0);
    check("reset_ready", 32'(o_ready), 32'd1);

    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, 4'(i), res, rtag, lat);
      check($sformatf("vec%0d_sum", i), res, vecs[i].want);
      check($sformatf("vec%0d_tag", i), 32'(rtag), 32'(i));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    // Stream 8 ops with a 4-cycle downstream stall in the middle.
    repeat (3) @(negedge clk);
    sent = 0;
    recv = 0;
    for (int c = 0; c < 60 && recv < 8; c++) begin
      @(negedge clk);
      ready    = !(c >= 5 && c < 9);
      in_valid = (sent < 8);
      a        = 32'h3F80_0000 + (32'(sent) << 23);
      b        = a;
      sub      = 1'b0;
      tag      = 4'(sent);
      #1;
      if (o_valid && !ready) begin
        check("stall_ready_low", 32'(o_ready), 32'd0);
        check("stall_sum_hold", o_sum, stream_want(recv));
        check("stall_tag_hold", 32'(o_tag), 32'(recv));
      end
      if (ready) check("stream_ready_high", 32'(o_ready), 32'd1);
      if (o_valid && ready) begin
        check("stream_sum", o_sum, stream_want(recv));
        check("stream_tag", 32'(o_tag), 32'(recv));
        recv++;
      end
      if (in_valid && o_ready) sent++;
    end
    check("stream_sent", 32'(sent), 32'd8);
    check("stream_received", 32'(recv), 32'd8);
    @(negedge clk);
    in_valid = 1'b0;
    ready    = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("stream_no_extra", 32'(o_valid), 32'd0);
    end

    // Reset with three ops in flight.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a = 32'h3F80_0000; b = 32'h3F80_0000; sub = 1'b0; tag = 4'hA + 4'(c);
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_sum", o_sum, 32'd0);
    check("midrst_tag", 32'(o_tag), 32'd0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("midrst_no_stale", 32'(o_valid), 32'd0);
    end

    // Half-precision instance.
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      h_a = hvecs[i].a; h_b = hvecs[i].b; h_sub = hvecs[i].sub; h_tag = 4'(i + 5);
      h_valid = 1'b1;
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      h_valid = 1'b0;
      while (!h_ovalid && lat < 10) begin
        @(posedge clk);
        lat++;
        @(negedge clk);
      end
      check($sformatf("fp16_%0d_sum", i), 32'(h_sum), 32'(hvecs[i].want));
      check($sformatf("fp16_%0d_tag", i), 32'(h_otag), 32'(i + 5));
      check($sformatf("fp16_%0d_latency", i), 32'(lat), 32'd3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_add_pipe.md
Name: fp_add_pipe

Overview:
- Parametrised, pipelined IEEE-754-style floating-point adder/subtractor; the next generation of the team's combinational 32-bit adder.
- Exponent and mantissa widths are generic, so fp16, bf16 and fp32 are all supported.
- Adds a subtract mode, full-width alignment with guard/round/sticky bits, overflow-to-infinity, and a 3-stage valid/ready pipeline with back-pressure.
- Sits between operand buffers and the accumulate/writeback path of the datapath.

Parameters:
- EXP_W, 8, exponent field width (bias = 2^(EXP_W-1)-1)
- MAN_W, 23, stored fraction width (hidden bit excluded)
- TAG_W, 4, width of the sideband tag carried alongside each operation

Ports:
- iCLK  input  1  clock; all state changes on its rising edge
- iRST  input  1  synchronous, active-high reset
- iValid  input  1  input operands valid
- oReady  output  1  adder can accept an input this cycle
- iA  input  EXP_W+MAN_W+1  operand A {sign, exp, frac}
- iB  input  EXP_W+MAN_W+1  operand B
- iSub  input  1  1: compute A-B (B sign inverted at entry); 0: A+B
- iTag  input  TAG_W  sideband tag, returned unchanged with the result
- oValid  output  1  result valid
- iReady  input  1  downstream accepts the result
- oSum  output  EXP_W+MAN_W+1  result
- oTag  output  TAG_W  tag of the operation in oSum

Behaviour:
- Reset (iRST=1 at a clock edge): all stage valid bits clear; oValid=0; oSum=0; oTag=0. Reset mid-operation discards every in-flight operation with no output.
- Pipeline enable: en = ~oValid | iReady; oReady = en, combinational.
- Input transfer: iValid & oReady. All three stages advance together when en=1 and hold when en=0.
- Bubbles propagate as valid=0.
- Latency: exactly 3 cycles from transfer to oValid when iReady stays high. Throughput: 1 result/cycle.
- oSum/oTag stay stable while oValid=1 & iReady=0.
- Stage 1, compare/align:
  - Apply iSub to B's sign.
  - Unpack operands with the hidden bit.
  - Larger operand = larger exp, then larger frac on a tie.
  - Right-shift the smaller significand by the exponent difference into a (MAN_W+4)-bit field: hidden + frac + guard + round + sticky.
  - The sticky bit ORs every shifted-out bit.
  - A difference > MAN_W+3 yields smaller significand = 0 with sticky = (smaller operand != 0).
- Stage 2, add/subtract:
  - Signs equal: add.
  - Signs differ: larger minus smaller.
  - Result width MAN_W+5 (carry bit included).
  - Result sign = sign of the larger operand.
- Stage 3, normalise/pack:
  - Carry out: shift right 1, exp+1, sticky preserved.
  - Otherwise: leading-one detect and left shift, exp -= shift amount.
  - Default rounding is truncation.
- Special cases, in priority order:
  - Either exp all-ones (Inf/NaN): pass that operand through, A first.
  - Both exp==0: +0.
  - One exp==0 (zero/denormal flushed): output the other operand, with B's sign already adjusted by iSub.
  - Exact cancellation: +0.
  - Normalised exp <= 0: underflow, output +0.
  - Normalised exp >= 2^EXP_W-1: overflow, output signed infinity (exp all-ones, frac 0).
- Simultaneous input transfer and output drain are allowed in the same cycle.

Optional Feature:
- Macro: FP_ADD_PIPE_ROUND_RNE_EN.
- Defined: stage 3 applies round-to-nearest-even using guard/round/sticky.
  - A mantissa carry from rounding increments the exponent.
  - Rounding into exp all-ones produces signed infinity.
- Undefined: guard/round/sticky bits are discarded (truncate toward zero).
- Latency is 3 cycles in both builds.

Test Plan:
- Default params, iSub=0, A=0x3F800000, B=0x3F800000 -> oSum=0x40000000 exactly 3 cycles after the transfer, oTag=iTag.
- A=0x3FC00000, B=0x3E800000, iSub=1 -> 0x3FA00000. Separately, A=0x3F800000, B=0xBF800000, iSub=0 -> 0x00000000.
- A=0x7F7FFFFF, B=0x7F7FFFFF -> 0x7F800000. A=0x00000001, B=0x3F800000 -> 0x3F800000 (denormal flushed).
- A=0x3F800000, B=0x33C00000 -> 0x3F800000 without the macro; 0x3F800001 with FP_ADD_PIPE_ROUND_RNE_EN.
- Stream 8 back-to-back ops with tags 0..7, hold iReady=0 for 4 cycles mid-stream:
  - oReady drops while the pipeline is full.
  - No result is lost or duplicated; tags emerge in order.
  - oSum is stable during the stall.
- Assert iRST for 1 cycle with 3 ops in flight -> oValid=0, oSum=0 next cycle; no stale results afterwards. Params EXP_W=5, MAN_W=10: 0x3C00+0x3C00 -> 0x4000.
